// File: rtl/tiny16_pkg.sv
// tiny16_pkg: shared definitions for the tiny16 control sequencer.
//   - opcode values, sequencer state encoding, in-bus source encodings,
//     branch condition encodings and instruction field bit positions.
//   - op_defined(): true for every opcode the core implements.
//   - br_taken():   evaluates a BR condition code against the ALU flags.
package tiny16_pkg;

  // Opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_ALU  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Register in-bus source select
  localparam logic [1:0] IN_ALU = 2'd0;
  localparam logic [1:0] IN_MEM = 2'd1;
  localparam logic [1:0] IN_IMM = 2'd2;
  localparam logic [1:0] IN_IR  = 2'd3;

  // BR condition codes, instruction bits [9:8]
  localparam logic [1:0] BR_ALWAYS = 2'd0;
  localparam logic [1:0] BR_Z      = 2'd1;
  localparam logic [1:0] BR_NZ     = 2'd2;
  localparam logic [1:0] BR_N      = 2'd3;

  // Field LSB positions within the instruction word
  localparam int OP_LSB   = 12;
  localparam int DST_LSB  = 9;
  localparam int SRC_LSB  = 6;
  localparam int FUNC_LSB = 0;
  localparam int COND_LSB = 8;

  function automatic logic op_defined(input logic [3:0] op);
    return (op <= OP_BR) || (op == OP_HALT);
  endfunction

  function automatic logic br_taken(input logic [1:0] cond, input logic z, input logic n);
    logic taken;
    case (cond)
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = z;
      BR_NZ:     taken = !z;
      default:   taken = n;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: memory handshake and register-file control bundle.
//   master (sequencer): receives instr/mem_ack/flag_z/flag_n, drives
//     mem_rd_req/mem_wr_req/addr_sel, src_sel/dst_sel/in_sel/alu_op,
//     in_en/pc_en/jp_en/br_en/out_en, ir, halted, illegal.
//   slave (memory + datapath side): the opposite directions.
interface control_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic [DATA_W-1:0] instr;
  logic              mem_ack;
  logic              flag_z;
  logic              flag_n;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic              addr_sel;
  logic [SEL_W-1:0]  src_sel;
  logic [SEL_W-1:0]  dst_sel;
  logic [1:0]        in_sel;
  logic [2:0]        alu_op;
  logic              in_en;
  logic              pc_en;
  logic              jp_en;
  logic              br_en;
  logic              out_en;
  logic [DATA_W-1:0] ir;
  logic              halted;
  logic              illegal;

  modport master (
    input  instr, mem_ack, flag_z, flag_n,
    output mem_rd_req, mem_wr_req, addr_sel, src_sel, dst_sel, in_sel, alu_op,
           in_en, pc_en, jp_en, br_en, out_en, ir, halted, illegal
  );

  modport slave (
    output instr, mem_ack, flag_z, flag_n,
    input  mem_rd_req, mem_wr_req, addr_sel, src_sel, dst_sel, in_sel, alu_op,
           in_en, pc_en, jp_en, br_en, out_en, ir, halted, illegal
  );
endinterface

// File: rtl/control_sequencer_instr_decode.sv
// instr_decode: purely combinational map from sequencer state, IR fields,
// ALU flags and mem_ack to every control output of the sequencer.
//   in : state, opcode, dst_f, src_f, func_f, cond_f, flag_z, flag_n, mem_ack
//   out: memory request/address select, register selects, in_sel, alu_op,
//        the four mutually exclusive enables, out_en, halted, illegal.
// BOOT (and therefore the reset period) falls through to the all-zero defaults.
module instr_decode
  import tiny16_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  state_t           state,
  input  logic [3:0]       opcode,
  input  logic [SEL_W-1:0] dst_f,
  input  logic [SEL_W-1:0] src_f,
  input  logic [2:0]       func_f,
  input  logic [1:0]       cond_f,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             mem_ack,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  output logic             addr_sel,
  output logic [SEL_W-1:0] src_sel,
  output logic [SEL_W-1:0] dst_sel,
  output logic [1:0]       in_sel,
  output logic [2:0]       alu_op,
  output logic             in_en,
  output logic             pc_en,
  output logic             jp_en,
  output logic             br_en,
  output logic             out_en,
  output logic             halted,
  output logic             illegal
);

  always_comb begin
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    addr_sel   = 1'b0;
    src_sel    = '0;
    dst_sel    = '0;
    in_sel     = IN_ALU;
    alu_op     = 3'd0;
    in_en      = 1'b0;
    pc_en      = 1'b0;
    jp_en      = 1'b0;
    br_en      = 1'b0;
    out_en     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state)
      // addr_sel=0 and src_sel=0 point the memory address at the PC (r0)
      ST_FETCH: mem_rd_req = 1'b1;

      ST_DECODE: pc_en = 1'b1;

      ST_EXEC: begin
        src_sel = src_f;
        dst_sel = dst_f;
        case (opcode)
          // MOV goes through the ALU with function 0 (pass src)
          OP_MOV: in_en = 1'b1;
          OP_LDI: begin
            in_sel = IN_IMM;
            in_en  = 1'b1;
          end
          OP_ALU: begin
            alu_op = func_f;
            in_en  = 1'b1;
          end
          OP_JMP: begin
            in_sel = IN_IR;
            jp_en  = 1'b1;
          end
          OP_BR: begin
            in_sel = IN_IR;
            br_en  = br_taken(cond_f, flag_z, flag_n);
          end
          default: illegal = !op_defined(opcode);
        endcase
      end

      // Only LD and ST ever reach MEM
      ST_MEM: begin
        src_sel  = src_f;
        dst_sel  = dst_f;
        addr_sel = 1'b1;
        if (opcode == OP_LD) begin
          mem_rd_req = 1'b1;
          in_sel     = IN_MEM;
          in_en      = mem_ack; // write lands on the acknowledge edge
        end else begin
          mem_wr_req = 1'b1;
          out_en     = 1'b1;
        end
      end

      ST_HALT: halted = 1'b1;

      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for tiny16.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (state BOOT, IR cleared)
//   bus  : control_sequencer_if.master -- memory request/acknowledge,
//          instruction word, ALU flags in; register-file controls, IR,
//          halted and illegal out.
// The FSM and IR live here; all outputs come from instr_decode, so every
// output follows the state register and drops as soon as rst rises.
module control_sequencer
  import tiny16_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int SEL_W           = 3,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master bus
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, ir_next;

  logic [3:0]        opcode;
  logic [SEL_W-1:0]  dst_f;
  logic [SEL_W-1:0]  src_f;
  logic [2:0]        func_f;
  logic [1:0]        cond_f;

  assign opcode = ir_reg[OP_LSB +: 4];
  assign dst_f  = ir_reg[DST_LSB +: SEL_W];
  assign src_f  = ir_reg[SRC_LSB +: SEL_W];
  assign func_f = ir_reg[FUNC_LSB +: 3];
  assign cond_f = ir_reg[COND_LSB +: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_FETCH;
      ST_FETCH: begin
        // IR only ever loads on the fetch acknowledge edge
        if (bus.mem_ack) begin
          state_next = ST_DECODE;
          ir_next    = bus.instr;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_LD || opcode == OP_ST)
          state_next = ST_MEM;
        else if (opcode == OP_HALT || (HALT_ON_ILLEGAL && !op_defined(opcode)))
          state_next = ST_HALT;
        else
          state_next = ST_FETCH;
      end
      ST_MEM: if (bus.mem_ack) state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_BOOT;
    endcase
  end

  assign bus.ir = ir_reg;

  instr_decode #(
    .SEL_W (SEL_W)
  ) u_decode (
    .state      (state_reg),
    .opcode     (opcode),
    .dst_f      (dst_f),
    .src_f      (src_f),
    .func_f     (func_f),
    .cond_f     (cond_f),
    .flag_z     (bus.flag_z),
    .flag_n     (bus.flag_n),
    .mem_ack    (bus.mem_ack),
    .mem_rd_req (bus.mem_rd_req),
    .mem_wr_req (bus.mem_wr_req),
    .addr_sel   (bus.addr_sel),
    .src_sel    (bus.src_sel),
    .dst_sel    (bus.dst_sel),
    .in_sel     (bus.in_sel),
    .alu_op     (bus.alu_op),
    .in_en      (bus.in_en),
    .pc_en      (bus.pc_en),
    .jp_en      (bus.jp_en),
    .br_en      (bus.br_en),
    .out_en     (bus.out_en),
    .halted     (bus.halted),
    .illegal    (bus.illegal)
  );

endmodule
